// File: rtl/period_meter.sv
// period_meter: measures spacing between trigger events as a reload-style count (R+1 cycle gap reads R)
module period_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             trigger_in,
    input  logic             ack,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             overrun,
    output logic             overflow,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE} state_t;
    localparam logic [WIDTH-1:0] one = 1;
    state_t state, state_n;
    logic [WIDTH-1:0] count, count_n;
    logic capture, ovf_hit;
    always_comb begin
        state_n = state;
        count_n = count;
        capture = 1'b0;
        ovf_hit = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = WAIT_FIRST;
                    count_n = '0;
                end
                WAIT_FIRST: if (trigger_in) begin
                    state_n = MEASURE;
                    count_n = '0;
                end
                MEASURE: if (trigger_in) begin
                    capture = 1'b1;
                    count_n = '0;
                end else if (&count) begin
                    // gap too long to represent: drop back and re-arm
                    ovf_hit = 1'b1;
                    count_n = '0;
                    state_n = WAIT_FIRST;
                end else begin
                    count_n = count + one;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            if (capture) period <= count;
            // ack wins on the sticky flags, capture wins on valid
            period_valid <= capture | (period_valid & ~ack);
            overrun      <= ~ack & (overrun | (capture & period_valid));
            overflow     <= ~ack & (overflow | ovf_hit);
        end
    end
    assign busy = (state == MEASURE);
endmodule
